// File: rtl/receive.sv
// receive: 8N1 UART receiver, mid-bit sampling on an oversampling clock
module receive #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] word,
  output logic       recieve_ready
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t        r_state, w_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bitn, w_bitn;
  logic [7:0]    r_shreg, w_shreg;
  logic [7:0]    r_word, w_word;
  logic          r_rdy, w_rdy;
  logic          w_rxs, w_half, w_end;
  assign w_rxs = r_sync[1];
  assign w_half = r_cnt == CW'(HALF - 1);
  assign w_end = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign word = r_word;
  assign recieve_ready = r_rdy;
  // two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], rxd};
  end
  // frame state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
      r_word  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bitn  <= w_bitn;
      r_shreg <= w_shreg;
      r_word  <= w_word;
      r_rdy   <= w_rdy;
    end
  end
  // next-state: start validated at half bit, then sample every full bit period
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bitn  = r_bitn;
    w_shreg = r_shreg;
    w_word  = r_word;
    w_rdy   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_state = START;
          w_cnt   = '0;
        end
      end
      START: begin
        if (w_half) begin
          w_cnt   = '0;
          w_bitn  = '0;
          w_state = w_rxs ? IDLE : DATA;
        end else w_cnt = r_cnt + CW'(1);
      end
      DATA: begin
        if (w_end) begin
          w_shreg = {w_rxs, r_shreg[7:1]};
          w_cnt   = '0;
          w_bitn  = r_bitn + 3'd1;
          if (r_bitn == 3'd7) w_state = STOP;
        end else w_cnt = r_cnt + CW'(1);
      end
      STOP: begin
        if (w_end) begin
          w_cnt = '0;
          if (w_rxs) begin
            w_word  = r_shreg;
            w_rdy   = 1'b1;
            w_state = IDLE;
          end else w_state = WAIT_HIGH;
        end else w_cnt = r_cnt + CW'(1);
      end
      WAIT_HIGH: begin
        if (w_rxs) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_receive.sv
// tb_receive: directed frame tests for the UART receiver
module tb_receive;
  localparam int C = 16;
  logic       clk, rst, rxd, recieve_ready;
  logic [7:0] word;
  int         n_vec = 0, n_err = 0, n_stb = 0, cyc = 0, t0;
  int         stb_cyc[$];
  logic [7:0] stb_word[$];

  receive #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .word(word), .recieve_ready(recieve_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge counter: after the posedge numbered N, cyc == N
  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor: each high cycle is one strobe, so a wide pulse shows up as an extra count
  always @(negedge clk) begin
    if (recieve_ready) begin
      n_stb++;
      stb_cyc.push_back(cyc);
      stb_word.push_back(word);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_stb = 0;
    stb_cyc.delete();
    stb_word.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic stp);
    rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(C);
    end
    rxd = stp;
    tick(C);
  endtask

  initial begin
    rst = 1'b0;
    rxd = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      rxd = i[0];
      @(negedge clk);
      chk("rst_word", word, 8'h00);
      chk("rst_rdy", recieve_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    rst = 1'b1;
    tick(30);
    chk("rst_nostb", n_stb, 0);

    clr();
    t0 = cyc;
    send(8'hA5, 1'b1);
    tick(20);
    chk("a5_count", n_stb, 1);
    chk("a5_latency", stb_cyc[0] - t0, 155);
    chk("a5_strobe_word", stb_word[0], 8'hA5);
    chk("a5_held", word, 8'hA5);

    clr();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    tick(20);
    chk("b2b_count", n_stb, 2);
    chk("b2b_gap", stb_cyc[1] - stb_cyc[0], 160);
    chk("b2b_word0", stb_word[0], 8'h00);
    chk("b2b_word1", stb_word[1], 8'hFF);

    clr();
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(400);
    chk("false_count", n_stb, 0);
    chk("false_word", word, 8'hFF);

    clr();
    send(8'h3C, 1'b0);
    rxd = 1'b0;
    tick(40);
    rxd = 1'b1;
    tick(20);
    chk("ferr_count", n_stb, 0);
    chk("ferr_word", word, 8'hFF);
    send(8'h81, 1'b1);
    tick(20);
    chk("ferr_next_count", n_stb, 1);
    chk("ferr_next_word", word, 8'h81);

    clr();
    rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0] ? 1'b0 : 1'b1;
      tick(C);
    end
    rxd = 1'b1;
    tick(C / 2);
    rst = 1'b0;
    tick(2);
    chk("midrst_word", word, 8'h00);
    chk("midrst_rdy", recieve_ready, 1'b0);
    rst = 1'b1;
    tick(C * 6);
    chk("midrst_nostb", n_stb, 0);
    clr();
    send(8'h12, 1'b1);
    tick(20);
    chk("after_rst_count", n_stb, 1);
    chk("after_rst_word", word, 8'h12);
    chk("after_rst_strobe_word", stb_word[0], 8'h12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
